// File: rtl/cpu1.sv
// rtl/cpu1.sv - five-phase multicycle 16-bit register-register CPU core
`ifndef CPU1_DEFINES
`define CPU1_DEFINES
`define OP_NOP   4'h0
`define OP_LOADI 4'h1
`define OP_ADD   4'h2
`define OP_SUB   4'h3
`define OP_AND   4'h4
`define OP_OR    4'h5
`define OP_XOR   4'h6
`endif

module cpu1_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr1,
  input  logic [2:0]  raddr2,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2
);

  logic [15:0] r [0:7];

  assign rdata1 = r[raddr1];
  assign rdata2 = r[raddr2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r[i] <= 16'h0000;
    end else if (we) begin
      r[waddr] <= wdata;
    end
  end

endmodule

module cpu1 (
  input  logic        clk,
  input  logic        res,
  input  logic [15:0] INST
);

  typedef enum logic [2:0] {
    PH_FETCH  = 3'd0,
    PH_DECODE = 3'd1,
    PH_EXEC   = 3'd2,
    PH_MEM    = 3'd3,
    PH_WB     = 3'd4
  } phase_t;

  phase_t      phase;
  logic [15:0] ir;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic        wb_en;
  logic [15:0] alu_out;
  logic [15:0] rdata1;
  logic [15:0] rdata2;

  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [15:0] imm;

  assign opcode = ir[15:12];
  assign rd     = ir[11:9];
  assign rs1    = ir[8:6];
  assign rs2    = ir[5:3];
  assign imm    = {7'b0, ir[8:0]};

  function automatic logic writes_rd(input logic [3:0] op);
    case (op)
      `OP_LOADI, `OP_ADD, `OP_SUB, `OP_AND, `OP_OR, `OP_XOR: writes_rd = 1'b1;
      default:                                               writes_rd = 1'b0;
    endcase
  endfunction

  always_comb begin
    alu_out = 16'h0000;
    case (opcode)
      `OP_LOADI: alu_out = imm;
      `OP_ADD:   alu_out = a + b;
      `OP_SUB:   alu_out = a - b;
      `OP_AND:   alu_out = a & b;
      `OP_OR:    alu_out = a | b;
      `OP_XOR:   alu_out = a ^ b;
      default:   alu_out = 16'h0000;
    endcase
  end

  // Write enable is armed in MEM so the register file commits on the WB edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      phase <= PH_FETCH;
      ir    <= 16'h0000;
      a     <= 16'h0000;
      b     <= 16'h0000;
      c     <= 16'h0000;
      wb_en <= 1'b0;
    end else begin
      case (phase)
        PH_FETCH: begin
          ir    <= INST;
          phase <= PH_DECODE;
        end
        PH_DECODE: begin
          a     <= rdata1;
          b     <= rdata2;
          phase <= PH_EXEC;
        end
        PH_EXEC: begin
          c     <= alu_out;
          phase <= PH_MEM;
        end
        PH_MEM: begin
          wb_en <= writes_rd(opcode);
          phase <= PH_WB;
        end
        PH_WB: begin
          wb_en <= 1'b0;
          phase <= PH_FETCH;
        end
        default: begin
          wb_en <= 1'b0;
          phase <= PH_FETCH;
        end
      endcase
    end
  end

  cpu1_regfile regfile (
    .clk    (clk),
    .rst_n  (res),
    .we     (wb_en),
    .waddr  (rd),
    .wdata  (c),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

endmodule

// File: tb/tb_cpu1.sv
// tb/tb_cpu1.sv - randomized self-checking bench for cpu1 against an architectural model
module tb_cpu1;

  logic        clk;
  logic        res;
  logic [15:0] INST;

  int n_checks;
  int n_fail;

  bit [15:0] m [8];

  cpu1 dut (
    .clk  (clk),
    .res  (res),
    .INST (INST)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rt(input logic [3:0] op, input int d, input int s1, input int s2);
    rt = {op, 3'(d), 3'(s1), 3'(s2), 3'b000};
  endfunction

  function automatic logic [15:0] li(input int d, input int imm);
    li = {4'h1, 3'(d), 9'(imm)};
  endfunction

  task automatic model_exec(input logic [15:0] inst);
    bit [15:0] x, y;
    int d;
    d = int'(inst[11:9]);
    x = m[inst[8:6]];
    y = m[inst[5:3]];
    case (inst[15:12])
      4'h1: m[d] = {7'b0, inst[8:0]};
      4'h2: m[d] = x + y;
      4'h3: m[d] = x - y;
      4'h4: m[d] = x & y;
      4'h5: m[d] = x | y;
      4'h6: m[d] = x ^ y;
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s r%0d", tag, i), dut.regfile.r[i], m[i]);
  endtask

  // Entered and left on a falling edge; the next rising edge is the FETCH edge.
  task automatic run_inst(input logic [15:0] inst, input bit garble, input string tag);
    int d;
    d = int'(inst[11:9]);
    INST = inst;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (garble && k < 4) INST = 16'($urandom);
      if (k == 3) check($sformatf("%s pre-wb r%0d", tag, d), dut.regfile.r[d], m[d]);
    end
    model_exec(inst);
    check_all(tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = 16'h0000;
  endtask

  initial begin
    logic [15:0] inst;
    logic [3:0]  op;
    n_checks = 0;
    n_fail   = 0;
    model_reset();

    res  = 1'b0;
    INST = 16'h0000;
    #1;
    check_all("reset");
    check("reset ir", dut.ir, 16'h0000);
    check("reset c", dut.c, 16'h0000);
    @(negedge clk);
    res = 1'b1;

    run_inst(li(1, 6), 1'b0, "loadi r1");
    check("loadi r1 val", dut.regfile.r[1], 16'd6);
    run_inst(li(2, 3), 1'b0, "loadi r2");
    run_inst(rt(4'h2, 3, 1, 2), 1'b0, "add r3");
    check("add r3 val", dut.regfile.r[3], 16'd9);
    run_inst(rt(4'h3, 3, 3, 1), 1'b0, "sub r3");
    check("sub r3 val", dut.regfile.r[3], 16'd3);
    run_inst(16'h0000, 1'b0, "nop a");
    run_inst(16'h0000, 1'b0, "nop b");
    run_inst(rt(4'h4, 4, 1, 2), 1'b0, "and");
    check("and r4 val", dut.regfile.r[4], 16'd2);
    run_inst(rt(4'h5, 5, 1, 2), 1'b0, "or");
    check("or r5 val", dut.regfile.r[5], 16'd7);
    run_inst(rt(4'h6, 6, 1, 2), 1'b0, "xor");
    check("xor r6 val", dut.regfile.r[6], 16'd5);
    run_inst(rt(4'hF, 1, 2, 3), 1'b0, "op f");
    run_inst(li(0, 9'h1FF), 1'b0, "loadi r0");
    run_inst(li(1, 1), 1'b0, "loadi r1b");
    run_inst(rt(4'h3, 2, 1, 0), 1'b0, "sub wrap");
    check("sub wrap val", dut.regfile.r[2], 16'hFE02);
    run_inst(li(4, 9'h1FF), 1'b0, "loadi r4");
    run_inst(rt(4'h2, 5, 4, 4), 1'b0, "add dbl");
    check("add dbl val", dut.regfile.r[5], 16'h03FE);
    run_inst(rt(4'h2, 7, 5, 2), 1'b1, "garbled");

    // Abort an ADD r3 in EXEC: asynchronous clear, no write-back afterwards.
    INST = rt(4'h2, 3, 4, 5);
    @(posedge clk);
    @(posedge clk);
    #2;
    res = 1'b0;
    #1;
    model_reset();
    check_all("abort");
    check("abort ir", dut.ir, 16'h0000);
    @(negedge clk);
    res = 1'b1;
    run_inst(li(1, 9'h0AB), 1'b0, "post abort");
    check("post abort r3", dut.regfile.r[3], 16'h0000);

    for (int t = 0; t < 40; t++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
      inst = 16'($urandom);
      inst[15:12] = op;
      run_inst(inst, 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu1.md
# cpu1

Minimal multicycle 16-bit register-register CPU core. Takes one 16-bit instruction word on `INST`, runs it through a fixed five-phase sequence (fetch, decode, execute, memory, write-back), and updates an internal eight-entry register file. There are no data outputs. Architectural state is observed hierarchically through the register-file instance `regfile` and its array `r[0:7]`.

## Interface
- No parameters.
- Data width is fixed at 16 bits.
- Register count is fixed at 8.
- `clk` — input, 1 bit. Single clock; all state updates on the rising edge.
- `res` — input, 1 bit. Reset, asynchronous, active-low.
- `INST` — input, 16 bits. Instruction word, sampled only in the FETCH phase.

## Operation
- **Opcode encoding** (`INST[15:12]`, defined as `OP_*` macros in a shared defines file):
  - `OP_NOP` = 4'h0
  - `OP_LOADI` = 4'h1
  - `OP_ADD` = 4'h2
  - `OP_SUB` = 4'h3
  - `OP_AND` = 4'h4
  - `OP_OR` = 4'h5
  - `OP_XOR` = 4'h6
  - All other codes execute as NOP.
- **Field layout**:
  - `rd` = `INST[11:9]`.
  - R-type: `rs1` = `INST[8:6]`, `rs2` = `INST[5:3]`. `INST[2:0]` is ignored.
  - LOADI: `imm9` = `INST[8:0]`, zero-extended to 16 bits.
- **Semantics**:
  - LOADI: `r[rd] = imm9`.
  - ADD: `r[rd] = r[rs1] + r[rs2]`.
  - SUB: `r[rd] = r[rs1] - r[rs2]`.
  - AND, OR, XOR: `r[rd] = r[rs1] op r[rs2]`.
  - NOP: no register change.
- **Arithmetic**: modulo 2^16, two's complement. No flags, carry or overflow are kept.
- **Register file**: 8 x 16-bit. `r[0]` is an ordinary writable register, not hardwired to zero.
  - Two combinational read ports.
  - One synchronous write port with enable.
  - Implemented as a submodule instance named `regfile` holding array `r`.
- **Internal registers**:
  - Phase register.
  - IR, 16 bits.
  - Operand latches A and B, 16 bits each.
  - Result latch C, 16 bits.
- **Phase FSM** (one cycle each, unconditional):
  - FETCH → DECODE → EXEC → MEM → WB → FETCH.
  - FETCH: IR ← `INST`.
  - DECODE: A ← `r[IR.rs1]`, B ← `r[IR.rs2]`.
  - EXEC: C ← ALU(opcode, A, B, imm9).
  - MEM: no operation. Reserved for future load/store; C is held.
  - WB: if opcode is LOADI/ADD/SUB/AND/OR/XOR, `r[IR.rd]` ← C. Otherwise nothing is written.
- **Register reuse**: `rd` may equal `rs1` and/or `rs2`. Operands are latched in DECODE, so the write-back of the same instruction never affects its own operands.

## Timing
- **Reset** (`res` low): immediately, without waiting for a clock edge:
  - phase = FETCH
  - IR = 16'h0000, A = B = C = 0
  - all `r[0..7]` = 16'h0000
- **Leaving reset**: FSM held in FETCH while `res` is low. The first FETCH edge is the first rising `clk` with `res` high.
- **Reset mid-instruction**: aborts the instruction; no write-back occurs. Registers take the reset values.
- **Latency**: exactly 5 cycles per instruction, fixed for all opcodes.
  - Write-back becomes visible in `r[rd]` after the 5th rising edge counted from the FETCH edge.
  - Throughput is 1 instruction per 5 cycles; there is no overlap.
- **`INST` handshake**: none.
  - `INST` must be stable at the FETCH rising edge.
  - Changes during the other four phases are ignored.
  - A stimulus that changes `INST` every 5 cycles, aligned to reset release, issues exactly one instruction per change.

## Test plan
- **Reset**: drive `res` low mid-run → all `r[i]` = 0 and phase = FETCH asynchronously. After release, the first instruction fetched is the one present at the first rising edge.
- **LOADI and ADD**:
  - LOADI r1,6 (5 cycles) → r1 = 6.
  - LOADI r2,3 → r2 = 3.
  - ADD r3,r1,r2 → r3 = 9.
  - Other registers stay 0.
- **SUB with rd = rs1 and NOP**:
  - Continuing from the previous scenario, SUB r3,r3,r1 → r3 = 3.
  - NOP held for 10 cycles → r1 = 6, r2 = 3, r3 = 3, all unchanged.
- **Wrap-around and immediate range**:
  - LOADI r0,0x1FF; LOADI r1,1; SUB r2,r1,r0 → r2 = 16'hFE02.
  - LOADI r4,0x1FF; ADD r5,r4,r4 → r5 = 16'h03FE.
- **Logic ops**: r1 = 6, r2 = 3.
  - AND r4,r1,r2 → r4 = 2.
  - OR r5,r1,r2 → r5 = 7.
  - XOR r6,r1,r2 → r6 = 5.
  - Unused opcode 4'hF → no register changes.
- **Timing and abort**:
  - `INST` altered during DECODE..WB → result still reflects the fetched word.
  - `res` pulsed low during EXEC of ADD r3 → r3 stays 0.
